// File: rtl/dff_bank_pkg.sv
// Shared opcode and FSM state encodings for the DFF bank sequencing controller.
// DFF_BANK_READBACK_EN adds the VERIFY state.
package dff_bank_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_LOAD   = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_PRESET = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PULSE = 3'd2,
    ST_RECOV = 3'd3,
    ST_DONE  = 3'd4
`ifdef DFF_BANK_READBACK_EN
    ,
    ST_VERIFY = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/dff_bank_ctrl_if.sv
// Requester port bundle: level request, opcode and load data in, one-cycle grant back.
interface dff_bank_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req;
  logic [1:0]       op;
  logic [WIDTH-1:0] data;
  logic             gnt;

  modport master (output req, output op, output data, input gnt);
  modport slave  (input req, input op, input data, output gnt);
endinterface

// File: rtl/dff_bank_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer only moves when a grant is taken (en).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // last_q = 1 means requester 1 won most recently, so requester 0 is favoured
  logic last_q, last_d;

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    if (req[0] && (!req[1] || last_q)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
    if (en && gnt[0]) begin
      last_d = 1'b0;
    end else if (en && gnt[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dff_bank_ctrl.sv
// Sequencing controller for an async-clear/preset DFF bank with round-robin requesters.
// Optional readback check of bank_Q enabled by DFF_BANK_READBACK_EN.
module dff_bank_ctrl
  import dff_bank_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned RECOV_LEN = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  dff_bank_ctrl_if.slave    rq0,
  dff_bank_ctrl_if.slave    rq1,
  output logic [WIDTH-1:0]  bank_D,
  output logic              bank_load,
  output logic              bank_CLR_n,
  output logic              bank_PRE_n,
  input  logic [WIDTH-1:0]  bank_Q,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic              done_err
);

  localparam int unsigned CNT_MAX = (PULSE_LEN > RECOV_LEN) ? PULSE_LEN : RECOV_LEN;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  typedef logic [CW-1:0] cnt_t;

`ifdef DFF_BANK_READBACK_EN
  localparam state_e ST_AFTER = ST_VERIFY;
`else
  localparam state_e ST_AFTER = ST_DONE;
`endif

  state_e           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             load_q, load_d;
  logic             clr_n_q, clr_n_d, pre_n_q, pre_n_d;
  logic             done_q, done_d, done_id_q, done_id_d;
  logic [1:0]       win;

  rr_arb2 u_arb (
    .clk   (CLK),
    .rst_n (CLR),
    .req   ({rq1.req, rq0.req}),
    .en    (state_q == ST_IDLE),
    .gnt   (win)
  );

`ifdef DFF_BANK_READBACK_EN
  logic             err_q, err_d;
  logic             done_err_q, done_err_d;
  logic [WIDTH-1:0] expect_val;

  always_comb begin
    case (op_q)
      OP_CLEAR:  expect_val = '0;
      OP_PRESET: expect_val = '1;
      default:   expect_val = data_q;
    endcase
  end
`else
  logic unused_bank_q;
  assign unused_bank_q = ^bank_Q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    id_d    = id_q;
    data_d  = data_q;
`ifdef DFF_BANK_READBACK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win != 2'b00) begin
          id_d   = win[1];
          op_d   = win[1] ? op_e'(rq1.op) : op_e'(rq0.op);
          data_d = win[1] ? rq1.data : rq0.data;
`ifdef DFF_BANK_READBACK_EN
          err_d  = 1'b0;
`endif
          case (op_d)
            OP_NOP:  state_d = ST_DONE;
            OP_LOAD: state_d = ST_LOAD;
            default: begin
              state_d = ST_PULSE;
              cnt_d   = cnt_t'(PULSE_LEN - 1);
            end
          endcase
        end
      end
      ST_LOAD: state_d = ST_AFTER;
      ST_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (RECOV_LEN > 0) begin
          state_d = ST_RECOV;
          cnt_d   = cnt_t'(RECOV_LEN - 1);
        end else begin
          state_d = ST_AFTER;
        end
      end
      ST_RECOV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_AFTER;
        end
      end
`ifdef DFF_BANK_READBACK_EN
      ST_VERIFY: begin
        err_d   = (bank_Q != expect_val);
        state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so every bank/handshake pin comes straight off a flop
    gnt0_d    = (state_q == ST_IDLE) && win[0];
    gnt1_d    = (state_q == ST_IDLE) && win[1];
    load_d    = (state_d == ST_LOAD);
    clr_n_d   = !((state_d == ST_PULSE) && (op_d == OP_CLEAR));
    pre_n_d   = !((state_d == ST_PULSE) && (op_d == OP_PRESET));
    done_d    = (state_d == ST_DONE);
    done_id_d = (state_d == ST_DONE) && id_d;
`ifdef DFF_BANK_READBACK_EN
    done_err_d = (state_d == ST_DONE) && err_d;
`endif
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_NOP;
      id_q      <= 1'b0;
      data_q    <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      load_q    <= 1'b0;
      clr_n_q   <= 1'b0;
      pre_n_q   <= 1'b1;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      id_q      <= id_d;
      data_q    <= data_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      load_q    <= load_d;
      clr_n_q   <= clr_n_d;
      pre_n_q   <= pre_n_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

`ifdef DFF_BANK_READBACK_EN
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      err_q      <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      done_err_q <= done_err_d;
    end
  end
  assign done_err = done_err_q;
`else
  assign done_err = 1'b0;
`endif

  assign rq0.gnt    = gnt0_q;
  assign rq1.gnt    = gnt1_q;
  assign bank_D     = data_q;
  assign bank_load  = load_q;
  assign bank_CLR_n = clr_n_q;
  assign bank_PRE_n = pre_n_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign done_id    = done_id_q;

endmodule

// File: doc/dff_bank_ctrl.md
Name: dff_bank_ctrl

Overview:
- Sequencing controller for a WIDTH-bit register bank built from async-clear/async-preset D flip-flops.
- Arbitrates two requesters round-robin. Each requester issues LOAD, CLEAR, PRESET or NOP commands.
- Drives the bank's D, load enable and active-low CLR/PRE pulses with timed assertion and recovery windows.
- Guarantees the bank's CLR and PRE are never low together.

Parameters:
- WIDTH, 8, bank data width.
- PULSE_LEN, 2, cycles a CLR/PRE pulse stays low (>=1).
- RECOV_LEN, 1, idle cycles after a pulse before DONE (>=0).

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 request, level.
- op0  in  2  requester 0 opcode.
- data0  in  WIDTH  requester 0 load data.
- gnt0  out  1  requester 0 grant, one-cycle pulse.
- req1  in  1  requester 1 request, level.
- op1  in  2  requester 1 opcode.
- data1  in  WIDTH  requester 1 load data.
- gnt1  out  1  requester 1 grant, one-cycle pulse.
- bank_D  out  WIDTH  data to bank D inputs.
- bank_load  out  1  bank clock enable, one cycle.
- bank_CLR_n  out  1  bank async clear, active low.
- bank_PRE_n  out  1  bank async preset, active low.
- bank_Q  in  WIDTH  bank outputs, used only with the optional feature.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester that owns the current done.
- done_err  out  1  readback mismatch, valid with done.

Behaviour:
- Opcodes: 00 NOP, 01 LOAD, 10 CLEAR, 11 PRESET.
- Reset (CLR low, asynchronous):
  - FSM goes to IDLE and round-robin pointer favours requester 0.
  - gnt0, gnt1, bank_load, busy, done, done_id, done_err all go 0; bank_D goes 0.
  - bank_PRE_n goes 1. bank_CLR_n goes 0 and is held low while CLR is low, so the bank is cleared with the controller.
  - Reset mid-operation aborts the command; no done is issued.
- States: IDLE, LOAD, PULSE, RECOV, DONE.
- IDLE:
  - At an edge with any req high, the winner is chosen: a sole requester wins; if both are high, the one not granted last wins.
  - The winner's op/data are latched. gntX is high for the following cycle only. busy rises in the same cycle.
  - Next state: NOP to DONE; LOAD to LOAD; CLEAR/PRESET to PULSE.
- LOAD: bank_D holds the latched data for the entire command; bank_load is high for exactly one cycle, then DONE.
- PULSE:
  - bank_CLR_n (CLEAR) or bank_PRE_n (PRESET) is low for exactly PULSE_LEN cycles.
  - Then RECOV, or DONE directly if RECOV_LEN = 0.
- RECOV: both bank_CLR_n and bank_PRE_n are high for RECOV_LEN cycles, then DONE.
- DONE:
  - done is high for one cycle; done_id = latched requester.
  - Next state IDLE; busy falls at that edge.
  - A new request is sampled only in IDLE, so there are at least 2 cycles between grants.
- Requesters deassert req in the gnt cycle. A req still high in IDLE is treated as a new request.
- Requests raised while busy wait; there is no queue beyond the req level.
- Timing at PULSE_LEN = 2, RECOV_LEN = 1: CLEAR takes grant cycle + 2 pulse + 1 recovery + 1 done.
- Invariants:
  - bank_CLR_n and bank_PRE_n are never both 0.
  - Both pulse outputs are driven directly from flops (glitch-free).
  - gnt0 and gnt1 are never both 1.

Optional Feature:
- Macro DFF_BANK_READBACK_EN.
- When defined:
  - A VERIFY state is inserted before DONE for LOAD/CLEAR/PRESET.
  - VERIFY compares bank_Q against the expected value: latched data, all zeros or all ones.
  - done_err = 1 with done on mismatch. NOP never errors.
- When undefined: no VERIFY state; done_err is tied 0; bank_Q is ignored.

Decomposition:
- Package dff_bank_pkg holds:
  - opcode constants OP_NOP, OP_LOAD, OP_CLEAR, OP_PRESET;
  - FSM state encoding.
- Sub-module rr_arb2: two-input round-robin arbiter with pointer update on grant.

Test Plan:
- Reset: hold CLR low 3 cycles -> bank_CLR_n = 0, bank_PRE_n = 1, all grants/done 0; release -> bank_CLR_n = 1 next edge, busy = 0.
- LOAD: req0, op0 = 01, data0 = 8'hA5 -> gnt0 one cycle; then bank_load one cycle with bank_D = A5; then done, done_id = 0.
- CLEAR with PULSE_LEN = 2, RECOV_LEN = 1: req1, op1 = 10 -> bank_CLR_n low exactly 2 cycles, 1 recovery cycle, then done, done_id = 1; bank_PRE_n stays 1.
- Contention: req0 and req1 both held with PRESET/LOAD -> grants alternate 1,0,1,... after a first grant to 0; never simultaneous; CLR_n/PRE_n never both low.
- Reset mid-pulse: assert CLR during a PRESET pulse -> bank_PRE_n returns 1 immediately, no done, FSM in IDLE after release.
- Readback (macro defined): LOAD 8'h3C with bank_Q forced 8'h3D -> done with done_err = 1; with bank_Q = 3C -> done_err = 0.
